// File: rtl/truth_table_pkg.sv
// Shared types and width helpers for the truth-table sweeper and the downstream table comparator.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    REPORT  = 2'd3
  } tt_state_e;

  localparam int unsigned MIN_N_IN = 1;
  localparam int unsigned MAX_N_IN = 6;

  // Number of input vectors for an n_in-input gate.
  function automatic int unsigned n_vec(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

  // One truth-table bit per input vector.
  function automatic int unsigned tt_width(input int unsigned n_in);
    return n_vec(n_in);
  endfunction

  // Vector index carries one spare bit so the terminal compare never relies on wrap-around.
  function automatic int unsigned idx_width(input int unsigned n_in);
    return $clog2(n_vec(n_in)) + 1;
  endfunction

  localparam int unsigned MAX_TT_W = tt_width(MAX_N_IN);

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle timer: after load, expired rises once SETTLE cycles have been counted from the load edge.
module tt_settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  if (SETTLE < 1) begin : g_bad_settle
    $error("tt_settle_timer: SETTLE must be >= 1");
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  // Counter saturates once expired so it never wraps while the FSM is elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      cnt_q   <= '0;
      expired <= (LAST == '0);
    end else if (!expired) begin
      cnt_q   <= cnt_inc;
      expired <= (cnt_inc == LAST);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector onto a gate under test, samples its output after a settle time,
// and hands the assembled truth table downstream over a valid/ready handshake.
module truth_table_sweeper
  import truth_table_pkg::n_vec;
  import truth_table_pkg::tt_state_e;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic [N_IN-1:0]         stim,
  input  logic                    dut_out,
  output logic                    tt_valid,
  input  logic                    tt_ready,
  output logic [n_vec(N_IN)-1:0]  tt_data
);

  localparam int unsigned NV = truth_table_pkg::n_vec(N_IN);
  localparam int unsigned TW = truth_table_pkg::tt_width(N_IN);
  localparam int unsigned IW = truth_table_pkg::idx_width(N_IN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NV - 1);

  if (N_IN < truth_table_pkg::MIN_N_IN || N_IN > truth_table_pkg::MAX_N_IN) begin : g_bad_n_in
    $error("truth_table_sweeper: N_IN must be in 1..6");
  end

  if (SETTLE < 1) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE must be >= 1");
  end

  tt_state_e       state_q;
  tt_state_e       state_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;
  logic [TW-1:0]   shadow_q;
  logic [TW-1:0]   shadow_d;
  logic [TW-1:0]   merged;
  logic            busy_d;
  logic [N_IN-1:0] stim_d;
  logic            tt_valid_d;
  logic [TW-1:0]   tt_data_d;
  logic            timer_load;
  logic            timer_expired;
  logic            last_vec;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .expired (timer_expired)
  );

  assign last_vec = (idx_q == LAST_IDX);

  // Shadow table with the sample of the current capture cycle folded in.
  always_comb begin
    merged = shadow_q;
    merged[idx_q[N_IN-1:0]] = dut_out;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= truth_table_pkg::IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      truth_table_pkg::IDLE: begin
        if (start) state_d = truth_table_pkg::SETTLE;
      end
      truth_table_pkg::SETTLE: begin
        if (timer_expired) state_d = truth_table_pkg::CAPTURE;
      end
      truth_table_pkg::CAPTURE: begin
        state_d = last_vec ? truth_table_pkg::REPORT : truth_table_pkg::SETTLE;
      end
      truth_table_pkg::REPORT: begin
        if (tt_ready) state_d = truth_table_pkg::IDLE;
      end
      default: state_d = truth_table_pkg::IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; everything holds unless changed below.
  always_comb begin
    busy_d     = busy;
    stim_d     = stim;
    tt_valid_d = tt_valid;
    tt_data_d  = tt_data;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    timer_load = 1'b0;
    case (state_q)
      truth_table_pkg::IDLE: begin
        if (start) begin
          idx_d      = '0;
          shadow_d   = '0;
          busy_d     = 1'b1;
          stim_d     = '0;
          timer_load = 1'b1;
        end
      end
      truth_table_pkg::CAPTURE: begin
        shadow_d = merged;
        if (last_vec) begin
          tt_data_d  = merged;
          tt_valid_d = 1'b1;
          busy_d     = 1'b0;
          stim_d     = '0;
        end else begin
          idx_d      = idx_q + IW'(1);
          stim_d     = N_IN'(idx_q + IW'(1));
          timer_load = 1'b1;
        end
      end
      truth_table_pkg::REPORT: begin
        if (tt_ready) tt_valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      stim     <= '0;
      tt_valid <= 1'b0;
      tt_data  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      busy     <= busy_d;
      stim     <= stim_d;
      tt_valid <= tt_valid_d;
      tt_data  <= tt_data_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: NAND3/AND3 sweeps, backpressure, reset, lagging gates.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;

  logic       start, tt_ready, dut_out, busy, tt_valid;
  logic [2:0] stim;
  logic [7:0] tt_data;

  logic       start3, tt_ready3, dut_out3, busy3, tt_valid3;
  logic [2:0] stim3;
  logic [7:0] tt_data3;

  logic       start1, tt_ready1, dut_out1, busy1, tt_valid1;
  logic [2:0] stim1;
  logic [7:0] tt_data1;

  logic gate_sel;
  logic dly1, dly2, lag1_a, lag1_b;

  int n_checks = 0;
  int n_errors = 0;
  int cur = 0;

  logic       m_valid, m_busy;
  logic [2:0] m_stim;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .stim(stim),
    .dut_out(dut_out), .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_data(tt_data)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .stim(stim3),
    .dut_out(dut_out3), .tt_valid(tt_valid3), .tt_ready(tt_ready3), .tt_data(tt_data3)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .stim(stim1),
    .dut_out(dut_out1), .tt_valid(tt_valid1), .tt_ready(tt_ready1), .tt_data(tt_data1)
  );

  // Gate models: NAND3 (optionally with a 2-cycle lag), AND3, lagged NAND3.
  always_ff @(posedge clk) begin
    dly1   <= ~&stim;
    dly2   <= dly1;
    lag1_a <= ~&stim1;
    lag1_b <= lag1_a;
  end

  assign dut_out  = gate_sel ? dly2 : ~&stim;
  assign dut_out3 = &stim3;
  assign dut_out1 = lag1_b;

  always_comb begin
    case (cur)
      1:       begin m_valid = tt_valid3; m_busy = busy3; m_stim = stim3; m_data = tt_data3; end
      2:       begin m_valid = tt_valid1; m_busy = busy1; m_stim = stim1; m_data = tt_data1; end
      default: begin m_valid = tt_valid;  m_busy = busy;  m_stim = stim;  m_data = tt_data;  end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      1:       start3 = v;
      2:       start1 = v;
      default: start  = v;
    endcase
  endtask

  // Pulse start, then watch every cycle until tt_valid (bounded), recording stim and busy.
  task automatic pulse_sweep(input int which, input int per_vec,
                             output int cyc, output int busy_cyc, output int stim_bad);
    logic [2:0] exp_stim;
    cur = which;
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    cyc = 0;
    busy_cyc = 0;
    stim_bad = 0;
    while (!m_valid && cyc < 200) begin
      exp_stim = 3'(cyc / per_vec);
      if (m_busy) busy_cyc++;
      if (m_stim !== exp_stim) stim_bad++;
      @(negedge clk);
      cyc++;
    end
    if (m_stim !== 3'd0) stim_bad++;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!tt_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, bcyc, sbad, bad, vcnt;
    rst_n = 1'b0;
    start = 1'b0; start3 = 1'b0; start1 = 1'b0;
    tt_ready = 1'b1; tt_ready3 = 1'b1; tt_ready1 = 1'b1;
    gate_sel = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy, 0);
    chk("rst_stim", stim, 0);
    chk("rst_valid", tt_valid, 0);
    chk("rst_data", tt_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // NAND3, SETTLE=2
    pulse_sweep(0, 3, cyc, bcyc, sbad);
    chk("nand3_latency", cyc, 24);
    chk("nand3_busy_cycles", bcyc, 24);
    chk("nand3_stim_seq", sbad, 0);
    chk("nand3_data", tt_data, 8'h7F);
    chk("nand3_busy_done", busy, 0);
    @(negedge clk);
    chk("nand3_valid_drop", tt_valid, 0);
    chk("nand3_data_retained", tt_data, 8'h7F);

    // AND3, SETTLE=3
    pulse_sweep(1, 4, cyc, bcyc, sbad);
    chk("and3_latency", cyc, 32);
    chk("and3_busy_cycles", bcyc, 32);
    chk("and3_stim_seq", sbad, 0);
    chk("and3_data", tt_data3, 8'h80);
    @(negedge clk);
    chk("and3_valid_drop", tt_valid3, 0);

    // Backpressure with a start pulse during REPORT
    tt_ready = 1'b0;
    pulse_sweep(0, 3, cyc, bcyc, sbad);
    chk("bp_latency", cyc, 24);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!tt_valid || tt_data !== 8'h7F || busy) bad++;
      start = (i == 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk("bp_stable", bad, 0);
    tt_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", tt_valid, 0);
    chk("bp_busy_after", busy, 0);
    @(negedge clk);
    chk("bp_start_not_queued", busy, 0);

    // Start held across the handshake cycle
    tt_ready = 1'b0;
    pulse_sweep(0, 3, cyc, bcyc, sbad);
    chk("hs_latency", cyc, 24);
    start = 1'b1;
    tt_ready = 1'b1;
    @(negedge clk);
    chk("hs_valid_drop", tt_valid, 0);
    chk("hs_not_accepted", busy, 0);
    @(negedge clk);
    chk("hs_accepted_next", busy, 1);
    start = 1'b0;
    wait_valid(cyc);
    chk("hs_second_latency", cyc, 24);
    chk("hs_second_data", tt_data, 8'h7F);
    @(negedge clk);

    // Reset mid-sweep
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stim", stim, 0);
    chk("mid_rst_valid", tt_valid, 0);
    chk("mid_rst_data", tt_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (tt_valid || busy) vcnt++;
      @(negedge clk);
    end
    chk("mid_rst_quiet", vcnt, 0);
    pulse_sweep(0, 3, cyc, bcyc, sbad);
    chk("post_rst_latency", cyc, 24);
    chk("post_rst_data", tt_data, 8'h7F);
    @(negedge clk);

    // Gate with a 2-cycle lag: SETTLE=2 is enough, SETTLE=1 samples the previous vector
    gate_sel = 1'b1;
    @(negedge clk);
    pulse_sweep(0, 3, cyc, bcyc, sbad);
    chk("lag_s2_latency", cyc, 24);
    chk("lag_s2_data", tt_data, 8'h7F);
    @(negedge clk);
    pulse_sweep(2, 2, cyc, bcyc, sbad);
    chk("lag_s1_latency", cyc, 16);
    chk("lag_s1_stim_seq", sbad, 0);
    chk("lag_s1_data", tt_data1, 8'hFF);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Upstream stimulus and capture stage for a combinational logic gate under characterisation, such as a 3-input gate defined by a case table on {in3,in2,in1}.
- On start, drives every input combination 0..2^N_IN-1 onto the gate in turn.
- Waits a programmable settle time for each vector, then samples the gate output.
- Assembles the samples into a 2^N_IN-bit truth-table word and hands it off with a valid/ready handshake.
- Its output is the measured truth table that the synthesis flow compares against the intended table (e.g. 8'h7F for a NAND3).

Parameters:
N_IN, 3, number of gate inputs (1..6).
SETTLE, 2, cycles each vector is held before sampling (>=1; elaboration error otherwise).

Ports:
clk      input   1         clock; all state changes on rising edge
rst_n    input   1         reset; asynchronous assert, active-low
start    input   1         sweep request; sampled only in IDLE
busy     output  1         high from start acceptance until tt_valid rises
stim     output  N_IN      vector to gate; bit0=in1, bit1=in2, bit2=in3
dut_out  input   1         gate output, combinational response to stim
tt_valid output  1         truth table available
tt_ready input   1         consumer accepts tt_data
tt_data  output  2^N_IN    bit k = dut_out sampled while stim==k

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, stim=0, tt_valid=0, tt_data=0.
  - Vector index, settle counter and shadow table cleared.
  - Reset mid-sweep discards the partial table; no tt_valid is produced.
- States: IDLE, SETTLE, CAPTURE, REPORT. All outputs are registered.
- IDLE:
  - start=1 -> SETTLE, idx=0, cnt=0, busy=1.
  - start=0 -> remain.
- SETTLE:
  - stim=idx; cnt increments each cycle.
  - When cnt==SETTLE-1 -> CAPTURE.
  - The state lasts exactly SETTLE cycles per vector.
- CAPTURE:
  - stim=idx; shadow[idx]<=dut_out.
  - If idx==2^N_IN-1 -> REPORT: tt_data<=shadow with the current sample merged in, tt_valid<=1, busy<=0.
  - Otherwise idx<=idx+1, cnt<=0 -> SETTLE.
- REPORT:
  - stim=0; tt_valid held high and tt_data held stable until tt_ready=1.
  - On tt_valid&&tt_ready: tt_valid<=0 -> IDLE.
- Latency: tt_valid rises exactly 2^N_IN*(SETTLE+1) cycles after the edge that samples start=1. Default: 8*3 = 24 cycles.
- stim is 0 in IDLE and REPORT. It changes only on the SETTLE entry edge, so each vector is held stable for SETTLE+1 cycles including the capture cycle.
- start is ignored in SETTLE, CAPTURE and REPORT; it is not queued.
- start=1 in the same cycle as the REPORT handshake is not accepted, since the state is not yet IDLE. Acceptance happens on the next IDLE cycle if start is still high.
- tt_data retains the last table after the handshake until the next REPORT entry or reset.
- tt_ready while tt_valid=0 has no effect.
- idx is a $clog2(2^N_IN)+1-bit counter; the terminal compare prevents wrap-around.
- dut_out is treated as synchronous to clk; no synchroniser.

Decomposition:
- Package truth_table_pkg:
  - state enum {IDLE, SETTLE, CAPTURE, REPORT};
  - function n_vec(N_IN) = 2**N_IN;
  - localparam truth-table width derivation.
  - Shared with the downstream table comparator.
- One sub-module, tt_settle_timer:
  - loadable down/up counter of width $clog2(SETTLE+1);
  - inputs clk, rst_n, load; output expired;
  - instantiated once for the SETTLE count.

Test Plan:
- Gate model NAND3 (out=~(in1&in2&in3)), default params, pulse start, tt_ready=1 -> tt_valid rises 24 cycles after start edge, tt_data=8'h7F, busy high for exactly those 24 cycles.
- Gate model AND3, SETTLE=3 -> tt_valid at cycle 32, tt_data=8'h80; each stim value held 4 cycles, observed sequence 0,1,...,7, then stim=0.
- Backpressure: tt_ready=0 for 10 cycles after tt_valid, start pulsed during REPORT -> tt_valid and tt_data=8'h7F stable all 10 cycles; start ignored; IDLE after the tt_ready=1 handshake.
- Simultaneous handshake and start: start held high across the REPORT handshake cycle -> new sweep accepted on the following cycle; second table correct.
- Reset mid-sweep: rst_n low at cycle 10 of a sweep -> outputs 0 asynchronously; tt_valid never asserts; a fresh sweep afterwards gives the correct table.
- Delayed gate: model out with 2-cycle lag. SETTLE=1 -> mismatched table (not 8'h7F). SETTLE=2 -> 8'h7F. This confirms sampling occurs on the last hold cycle.
